// File: rtl/opb_regbank_pkg.sv
// Shared definitions for the OPB register bank: the ack FSM state type,
// the byte-address-to-register-index mapping and the byte-lane geometry.
package opb_regbank_pkg;

   // Ack sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_WAIT = 2'd2
   } fsm_state_t;

   // Byte-lane geometry: lane k (OPB_BE[k], DBus[8k:8k+7]) lands in
   // register bits [WORD_MSB-LANE_W*k -: LANE_W]
   localparam int LANE_W    = 8;
   localparam int NUM_LANES = 4;
   localparam int WORD_MSB  = 31;

   function automatic int lane_msb(input int lane);
      return WORD_MSB - LANE_W * lane;
   endfunction

   // Word index of a byte address within the slave window
   function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                 input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/opb_slave_fsm.sv
// OPB slave front end: registers the bus request, decodes the window and the
// register index, runs the IDLE/ACK/WAIT ack sequencer and drives Sl_* data.
// Bus inputs are captured while idle, so the ack lands two cycles after the
// select is first sampled.
module opb_slave_fsm
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h01014000,
   parameter logic [31:0] C_HIGHADDR = 32'h010140FF,
   parameter int          C_NUM_IDX  = 4
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic [31:0]          abus,
   input  logic [NUM_LANES-1:0] be_lanes,
   input  logic [31:0]          wdata,
   input  logic                 rnw,
   input  logic                 select,
   input  logic [31:0]          rd_word,
   output logic [31:0]          idx,
   output logic [NUM_LANES-1:0] wr_lanes,
   output logic [31:0]          wr_data,
   output logic                 wr_en,
   output logic                 xfer_ack,
   output logic                 err_ack,
   output logic [31:0]          sl_dbus
);

   fsm_state_t           state_reg, state_next;
   logic                 sel_reg;
   logic                 rnw_reg;
   logic [31:0]          addr_reg;
   logic [31:0]          wdata_reg;
   logic [NUM_LANES-1:0] be_reg;
   logic                 hit;
   logic                 idx_err;

   assign hit      = sel_reg && (addr_reg >= C_BASEADDR) && (addr_reg <= C_HIGHADDR);
   assign idx      = addr_to_index(addr_reg, C_BASEADDR);
   assign idx_err  = (idx >= 32'(C_NUM_IDX));
   assign wr_lanes = be_reg;
   assign wr_data  = wdata_reg;

   // State register plus request capture; the request is frozen once a transfer starts
   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg <= ST_IDLE;
         sel_reg   <= 1'b0;
         rnw_reg   <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         be_reg    <= '0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= select;
         if (state_reg == ST_IDLE) begin
            rnw_reg   <= rnw;
            addr_reg  <= abus;
            wdata_reg <= wdata;
            be_reg    <= be_lanes;
         end
      end
   end

   // Next-state: one ack per hit, then hold off until the master drops select
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (hit) state_next = ST_ACK;
         ST_ACK:  state_next = ST_WAIT;
         ST_WAIT: if (!select) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs: everything is qualified by the ACK state so the data bus stays 0 otherwise
   always_comb begin
      xfer_ack = 1'b0;
      err_ack  = 1'b0;
      wr_en    = 1'b0;
      sl_dbus  = '0;
      if (state_reg == ST_ACK) begin
         xfer_ack = 1'b1;
         err_ack  = idx_err;
         wr_en    = !rnw_reg && !idx_err;
         if (rnw_reg && !idx_err) sl_dbus = rd_word;
      end
   end

endmodule

// File: rtl/opb_register_bank.sv
// OPB register bank: C_NUM_REGS 32-bit software registers behind an OPB slave
// window, with byte-lane writes and per-register write strobes.
// Optional macro OPB_REGBANK_SHADOW_EN: bus writes land in staging registers
// and a write to index C_NUM_REGS commits all of them to user_data_out at once.
module opb_register_bank
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01014000,
   parameter logic [31:0] C_HIGHADDR   = 32'h010140FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_NUM_REGS   = 4,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                     OPB_Clk,
   input  logic                     OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
   input  logic [0:3]               OPB_BE,
   input  logic [0:31]              OPB_DBus,
   input  logic                     OPB_RNW,
   input  logic                     OPB_select,
   input  logic                     OPB_seqAddr,
   output logic [0:31]              Sl_DBus,
   output logic                     Sl_xferAck,
   output logic                     Sl_errAck,
   output logic                     Sl_retry,
   output logic                     Sl_toutSup,
   output logic [C_NUM_REGS*32-1:0] user_data_out,
   output logic [C_NUM_REGS-1:0]    user_wr_strobe
);

`ifdef OPB_REGBANK_SHADOW_EN
   localparam int NUM_IDX = C_NUM_REGS + 1;
`else
   localparam int NUM_IDX = C_NUM_REGS;
`endif

   logic [31:0]           abus;
   logic [31:0]           wdata;
   logic [NUM_LANES-1:0]  be_lanes;
   logic [31:0]           idx;
   logic [NUM_LANES-1:0]  wr_lanes;
   logic [31:0]           wr_data;
   logic                  wr_en;
   logic [31:0]           rd_word;
   logic [31:0]           sl_dbus;
   logic [31:0]           bus_regs [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] strobe_reg;
   logic                  unused_inputs;

   // seqAddr is only a hint; accesses are handled one at a time
   assign unused_inputs = OPB_seqAddr;

   assign abus  = 32'(OPB_ABus);
   assign wdata = OPB_DBus;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign be_lanes[gi] = OPB_BE[gi];
   end

   opb_slave_fsm #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR),
      .C_NUM_IDX  (NUM_IDX)
   ) u_fsm (
      .clk      (OPB_Clk),
      .srst     (OPB_Rst),
      .abus     (abus),
      .be_lanes (be_lanes),
      .wdata    (wdata),
      .rnw      (OPB_RNW),
      .select   (OPB_select),
      .rd_word  (rd_word),
      .idx      (idx),
      .wr_lanes (wr_lanes),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .xfer_ack (Sl_xferAck),
      .err_ack  (Sl_errAck),
      .sl_dbus  (sl_dbus)
   );

   assign Sl_DBus    = sl_dbus;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // Read mux over the bus-visible registers; the commit slot reads as 0
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (idx == 32'(i)) rd_word = bus_regs[i];
      end
   end

`ifdef OPB_REGBANK_SHADOW_EN
   logic        commit;
   logic [31:0] out_regs [C_NUM_REGS];

   assign commit = wr_en && (idx == 32'(C_NUM_REGS));

   // Commit copies every staging register in the same edge
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         for (int i = 0; i < C_NUM_REGS; i++) out_regs[i] <= '0;
      end else if (commit) begin
         for (int i = 0; i < C_NUM_REGS; i++) out_regs[i] <= bus_regs[i];
      end
   end
`endif

   // Byte-lane register writes and write strobes; reset wins over a write in flight
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         for (int i = 0; i < C_NUM_REGS; i++) bus_regs[i] <= '0;
         strobe_reg <= '0;
      end else begin
         strobe_reg <= '0;
         for (int i = 0; i < C_NUM_REGS; i++) begin
            if (wr_en && (idx == 32'(i))) begin
               for (int k = 0; k < NUM_LANES; k++) begin
                  if (wr_lanes[k])
                     bus_regs[i][lane_msb(k) -: LANE_W] <= wr_data[lane_msb(k) -: LANE_W];
               end
`ifndef OPB_REGBANK_SHADOW_EN
               strobe_reg[i] <= 1'b1;
`endif
            end
         end
`ifdef OPB_REGBANK_SHADOW_EN
         if (commit) strobe_reg <= '1;
`endif
      end
   end

   assign user_wr_strobe = strobe_reg;

   for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_out
`ifdef OPB_REGBANK_SHADOW_EN
      assign user_data_out[32*gi +: 32] = out_regs[gi];
`else
      assign user_data_out[32*gi +: 32] = bus_regs[gi];
`endif
   end

endmodule
